// File: rtl/pingpong_input_buffer.sv
// Two-bank ping-pong frame buffer: the writer fills one bank while the reader randomly accesses the other.
// Optional macro PP_BUF_RD_REG_EN adds an output register stage (read latency 2 instead of 1).
module pingpong_input_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  rd_frame_avail,
  output logic [ADDR_WIDTH:0]   rd_frame_len,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_release,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  bank_state_t           state [2];
  logic [ADDR_WIDTH:0]   len   [2];
  logic [DATA_WIDTH-1:0] mem   [2*DEPTH];

  logic                  wr_sel;
  logic                  rd_sel;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  wr_fire;
  logic                  wr_close;
  logic                  rd_fire;
  logic                  rel_fire;
  logic                  in_range;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign wr_ready       = (state[wr_sel] != FULL);
  assign rd_frame_avail = (state[rd_sel] == FULL);
  assign rd_frame_len   = rd_frame_avail ? len[rd_sel] : '0;

  assign wr_fire  = wr_valid && wr_ready;
  assign wr_close = wr_fire && (wr_last || (&wr_ptr));
  assign rd_fire  = rd_en && rd_frame_avail;
  assign rel_fire = rd_release && rd_frame_avail;
  assign in_range = ({1'b0, rd_addr} < len[rd_sel]);

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_sel, wr_ptr}] <= wr_data;
  end

  // Writer completion and reader release always target different banks, so both may land in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state[0] <= EMPTY;
      state[1] <= EMPTY;
      len[0]   <= '0;
      len[1]   <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_valid && !wr_ready) overflow <= 1'b1;
      if (wr_fire) begin
        if (wr_close) begin
          state[wr_sel] <= FULL;
          len[wr_sel]   <= {1'b0, wr_ptr} + (ADDR_WIDTH+1)'(1);
          wr_ptr        <= '0;
          wr_sel        <= ~wr_sel;
        end else begin
          state[wr_sel] <= FILLING;
          wr_ptr        <= wr_ptr + ADDR_WIDTH'(1);
        end
      end
      if (rel_fire) begin
        state[rd_sel] <= EMPTY;
        rd_sel        <= ~rd_sel;
      end
    end
  end

  // Reads beyond the latched frame length return zero but are still flagged valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_data_q <= in_range ? mem[{rd_sel, rd_addr}] : '0;
    end
  end

`ifdef PP_BUF_RD_REG_EN
  logic                  rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_d <= 1'b0;
      rd_data_d  <= '0;
    end else begin
      rd_valid_d <= rd_valid_q;
      rd_data_d  <= rd_data_q;
    end
  end

  assign rd_valid = rd_valid_d;
  assign rd_data  = rd_data_d;
`else
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`endif

endmodule

// File: tb/tb_pingpong_input_buffer.sv
// Directed self-checking bench for pingpong_input_buffer (DATA_WIDTH=16, ADDR_WIDTH=3).
// Read latency follows PP_BUF_RD_REG_EN so the same bench covers both builds.
module tb_pingpong_input_buffer;

`ifdef PP_BUF_RD_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        rd_frame_avail;
  logic [3:0]  rd_frame_len;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_release;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  pingpong_input_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .rd_frame_avail(rd_frame_avail), .rd_frame_len(rd_frame_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_release(rd_release), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] data, input logic last);
    wr_valid = 1'b1;
    wr_data  = data;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic issue_read(input logic [2:0] addr);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 6;
    if (wr_ready !== 1'b1)       begin failures++; $display("[TB] FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    if (rd_frame_avail !== 1'b0) begin failures++; $display("[TB] FAIL reset_avail got=%b exp=0", rd_frame_avail); end
    if (rd_frame_len !== 4'd0)   begin failures++; $display("[TB] FAIL reset_len got=%0d exp=0", rd_frame_len); end
    if (rd_valid !== 1'b0)       begin failures++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    if (rd_data !== 16'h0000)    begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=0000", rd_data); end
    if (overflow !== 1'b0)       begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rd_frame_avail !== 1'b0) begin failures++; $display("[TB] FAIL short_avail_early word=%0d got=%b exp=0", i, rd_frame_avail); end
      write_word(16'h0100 + 16'(i), i == 4);
    end
    checks += 3;
    if (rd_frame_avail !== 1'b1) begin failures++; $display("[TB] FAIL short_avail got=%b exp=1", rd_frame_avail); end
    if (rd_frame_len !== 4'd5)   begin failures++; $display("[TB] FAIL short_len got=%0d exp=5", rd_frame_len); end
    if (wr_ready !== 1'b1)       begin failures++; $display("[TB] FAIL short_wr_ready got=%b exp=1", wr_ready); end
    issue_read(3'd2);
    checks += 2;
    if (rd_valid !== 1'b1)    begin failures++; $display("[TB] FAIL short_rd2_valid got=%b exp=1", rd_valid); end
    if (rd_data !== 16'h0102) begin failures++; $display("[TB] FAIL short_rd2_data got=%h exp=0102", rd_data); end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL short_rd_valid_drop got=%b exp=0", rd_valid); end
    issue_read(3'd0);
    checks++;
    if (rd_data !== 16'h0100) begin failures++; $display("[TB] FAIL short_rd0_data got=%h exp=0100", rd_data); end
  endtask

  task automatic test_out_of_range();
    issue_read(3'd4);
    checks++;
    if (rd_data !== 16'h0104) begin failures++; $display("[TB] FAIL oor_last_word got=%h exp=0104", rd_data); end
    issue_read(3'd5);
    checks += 2;
    if (rd_valid !== 1'b1)    begin failures++; $display("[TB] FAIL oor_rd5_valid got=%b exp=1", rd_valid); end
    if (rd_data !== 16'h0000) begin failures++; $display("[TB] FAIL oor_rd5_data got=%h exp=0000", rd_data); end
    issue_read(3'd6);
    checks += 2;
    if (rd_valid !== 1'b1)    begin failures++; $display("[TB] FAIL oor_rd6_valid got=%b exp=1", rd_valid); end
    if (rd_data !== 16'h0000) begin failures++; $display("[TB] FAIL oor_rd6_data got=%h exp=0000", rd_data); end
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    checks += 2;
    if (rd_frame_avail !== 1'b0) begin failures++; $display("[TB] FAIL release_avail got=%b exp=0", rd_frame_avail); end
    if (rd_frame_len !== 4'd0)   begin failures++; $display("[TB] FAIL release_len got=%0d exp=0", rd_frame_len); end
  endtask

  task automatic test_no_frame();
    issue_read(3'd1);
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL noframe_rd_valid got=%b exp=0", rd_valid); end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 8; i++) write_word(16'h0200 + 16'(i), 1'b0);
    checks += 3;
    if (rd_frame_avail !== 1'b1) begin failures++; $display("[TB] FAIL full_avail got=%b exp=1", rd_frame_avail); end
    if (rd_frame_len !== 4'd8)   begin failures++; $display("[TB] FAIL full_len got=%0d exp=8", rd_frame_len); end
    if (wr_ready !== 1'b1)       begin failures++; $display("[TB] FAIL full_wr_ready got=%b exp=1", wr_ready); end
    issue_read(3'd7);
    checks++;
    if (rd_data !== 16'h0207) begin failures++; $display("[TB] FAIL full_rd7_data got=%h exp=0207", rd_data); end
  endtask

  task automatic test_overflow();
    write_word(16'h0300, 1'b0);
    write_word(16'h0301, 1'b0);
    write_word(16'h0302, 1'b1);
    checks += 2;
    if (wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL both_full_wr_ready got=%b exp=0", wr_ready); end
    if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL pre_overflow got=%b exp=0", overflow); end
    write_word(16'hDEAD, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL overflow_set got=%b exp=1", overflow); end
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    checks += 3;
    if (wr_ready !== 1'b1)     begin failures++; $display("[TB] FAIL freed_wr_ready got=%b exp=1", wr_ready); end
    if (rd_frame_len !== 4'd3) begin failures++; $display("[TB] FAIL next_frame_len got=%0d exp=3", rd_frame_len); end
    if (overflow !== 1'b1)     begin failures++; $display("[TB] FAIL overflow_sticky got=%b exp=1", overflow); end
    issue_read(3'd1);
    checks++;
    if (rd_data !== 16'h0301) begin failures++; $display("[TB] FAIL next_frame_rd1 got=%h exp=0301", rd_data); end
  endtask

  task automatic test_back_to_back();
    write_word(16'h0400, 1'b0);
    wr_valid   = 1'b1;
    wr_data    = 16'h0401;
    wr_last    = 1'b1;
    rd_en      = 1'b1;
    rd_addr    = 3'd2;
    rd_release = 1'b1;
    tick();
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    rd_en      = 1'b0;
    rd_release = 1'b0;
    repeat (LAT - 1) tick();
    checks += 5;
    if (rd_valid !== 1'b1)       begin failures++; $display("[TB] FAIL b2b_rd_valid got=%b exp=1", rd_valid); end
    if (rd_data !== 16'h0302)    begin failures++; $display("[TB] FAIL b2b_rd_data got=%h exp=0302", rd_data); end
    if (rd_frame_avail !== 1'b1) begin failures++; $display("[TB] FAIL b2b_avail got=%b exp=1", rd_frame_avail); end
    if (rd_frame_len !== 4'd2)   begin failures++; $display("[TB] FAIL b2b_len got=%0d exp=2", rd_frame_len); end
    if (wr_ready !== 1'b1)       begin failures++; $display("[TB] FAIL b2b_wr_ready got=%b exp=1", wr_ready); end
    issue_read(3'd1);
    checks++;
    if (rd_data !== 16'h0401) begin failures++; $display("[TB] FAIL b2b_rd1 got=%h exp=0401", rd_data); end
  endtask

  task automatic test_reset_mid_frame();
    write_word(16'h0500, 1'b0);
    write_word(16'h0501, 1'b0);
    write_word(16'h0502, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 6;
    if (wr_ready !== 1'b1)       begin failures++; $display("[TB] FAIL midrst_wr_ready got=%b exp=1", wr_ready); end
    if (rd_frame_avail !== 1'b0) begin failures++; $display("[TB] FAIL midrst_avail got=%b exp=0", rd_frame_avail); end
    if (rd_frame_len !== 4'd0)   begin failures++; $display("[TB] FAIL midrst_len got=%0d exp=0", rd_frame_len); end
    if (rd_valid !== 1'b0)       begin failures++; $display("[TB] FAIL midrst_rd_valid got=%b exp=0", rd_valid); end
    if (rd_data !== 16'h0000)    begin failures++; $display("[TB] FAIL midrst_rd_data got=%h exp=0000", rd_data); end
    if (overflow !== 1'b0)       begin failures++; $display("[TB] FAIL midrst_overflow got=%b exp=0", overflow); end
    write_word(16'h0600, 1'b0);
    write_word(16'h0601, 1'b1);
    checks++;
    if (rd_frame_len !== 4'd2) begin failures++; $display("[TB] FAIL midrst_new_len got=%0d exp=2", rd_frame_len); end
    issue_read(3'd0);
    checks++;
    if (rd_data !== 16'h0600) begin failures++; $display("[TB] FAIL midrst_new_rd0 got=%h exp=0600", rd_data); end
  endtask

  initial begin
    rst        = 1'b1;
    wr_valid   = 1'b0;
    wr_data    = '0;
    wr_last    = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    rd_release = 1'b0;
    #1;
    test_reset();
    test_short_frame();
    test_out_of_range();
    test_no_frame();
    test_full_frame();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pingpong_input_buffer.md
PINGPONG_INPUT_BUFFER -- requirements
Module: pingpong_input_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, bank address width; DEPTH = 2**ADDR_WIDTH words per bank.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_valid  input  1  write word offered.
REQ-006 SHALL have port wr_ready  output  1  write word accepted when wr_valid&&wr_ready.
REQ-007 SHALL have port wr_data  input  DATA_WIDTH  write word.
REQ-008 SHALL have port wr_last  input  1  accepted word ends the current frame.
REQ-009 SHALL have port rd_frame_avail  output  1  a complete frame is readable.
REQ-010 SHALL have port rd_frame_len  output  ADDR_WIDTH+1  word count of the readable frame (1..DEPTH).
REQ-011 SHALL have port rd_en  input  1  random-access read request.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  read address within the readable frame.
REQ-013 SHALL have port rd_data  output  DATA_WIDTH  read word.
REQ-014 SHALL have port rd_valid  output  1  rd_data is valid this cycle.
REQ-015 SHALL have port rd_release  input  1  reader done; frees the readable bank.
REQ-016 SHALL have port overflow  output  1  sticky; wr_valid seen while wr_ready low.

Function
REQ-017 SHALL contain two banks of DEPTH x DATA_WIDTH; each bank is in one state: EMPTY, FILLING, FULL.
REQ-018 Writer SHALL fill the bank selected by wr_sel at sequential addresses from 0; the first accepted word moves it EMPTY->FILLING.
REQ-019 A bank SHALL move to FULL on an accepted word with wr_last=1 or on the DEPTH-th accepted word, latch its length, and toggle wr_sel in the same cycle.
REQ-020 wr_ready SHALL be 1 iff the bank at wr_sel is EMPTY or FILLING.
REQ-021 rd_frame_avail SHALL be 1 iff the bank at rd_sel is FULL; rd_frame_len SHALL show its latched length, else 0.
REQ-022 Read latency SHALL be 1 cycle: rd_en with rd_frame_avail=1 at cycle N gives rd_valid=1 and rd_data=bank[rd_sel][rd_addr] at N+1.
REQ-023 rd_en while rd_frame_avail=0 SHALL be ignored (rd_valid=0 next cycle).
REQ-024 rd_addr >= rd_frame_len SHALL return rd_data=0 with rd_valid=1.
REQ-025 rd_release with rd_frame_avail=1 SHALL set that bank EMPTY and toggle rd_sel next cycle; otherwise ignored.
REQ-026 Release of one bank and completion of the other in the same cycle SHALL both take effect; the bank freed SHALL be writable (wr_ready=1) the following cycle if it is at wr_sel.
REQ-027 rd_en and rd_release in the same cycle SHALL return the read data (read uses pre-release bank).
REQ-028 overflow SHALL set when wr_valid=1 and wr_ready=0, and stay set until reset.

Reset
REQ-029 On rst=1 at a clock edge: both banks EMPTY, wr_sel=rd_sel=0, write pointer 0, wr_ready=1, rd_frame_avail=0, rd_frame_len=0, rd_valid=0, rd_data=0, overflow=0; memory contents need not clear.
REQ-030 Reset mid-frame SHALL discard the partial frame and any FULL frames.

Configuration
REQ-031 Macro PP_BUF_RD_REG_EN defined: an extra output register SHALL be added; read latency 2 cycles, rd_valid/rd_data delayed one further cycle, both reset to 0.
REQ-032 Macro PP_BUF_RD_REG_EN undefined: read latency SHALL be exactly 1 cycle per REQ-022.

Verification (DATA_WIDTH=16, ADDR_WIDTH=3, macro undefined)
REQ-033 Write 0x0100..0x0104 with wr_last on 5th -> rd_frame_avail=1, rd_frame_len=5; rd_addr=2 -> rd_data=0x0102 one cycle later.
REQ-034 Write 8 words no wr_last -> frame closes at 8, rd_frame_len=8, wr_sel toggles, wr_ready stays 1 for bank 1.
REQ-035 Fill both banks without release -> wr_ready=0; further wr_valid -> overflow=1; rd_release -> wr_ready=1 next cycle.
REQ-036 rd_en with no frame -> rd_valid=0; rd_addr=6 on 5-word frame -> rd_data=0x0000, rd_valid=1.
REQ-037 Assert rst after 3 words of a frame -> all outputs at reset values; new frame starts at address 0.
REQ-038 Repeat REQ-033 with PP_BUF_RD_REG_EN defined -> rd_data=0x0102 two cycles after rd_en.
